// File: rtl/mux_arbiter_2to1_pkg.sv
// Shared definitions for the two-requester packet arbiter: datapath width,
// FSM state encodings and a small helper that maps a requester id to its
// ownership state.
package mux_arbiter_2to1_pkg;

   localparam int DATA_BITS = 16;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_OWN0 = 2'd1,
      ARB_OWN1 = 2'd2
   } arb_state_t;

   function automatic arb_state_t own_state(input logic id);
      return id ? ARB_OWN1 : ARB_OWN0;
   endfunction

endpackage

// File: rtl/mux_arbiter_2to1_mux2to1_16b.sv
// Shared 2:1 data multiplexer. sel = 0 picks Data_in1 (requester 0),
// sel = 1 picks Data_in2 (requester 1).
module MUX2to1_16b
   import mux_arbiter_2to1_pkg::*;
(
   input  logic                 sel,
   input  logic [DATA_BITS-1:0] Data_in1,
   input  logic [DATA_BITS-1:0] Data_in2,
   output logic [DATA_BITS-1:0] Data_out
);

   // Pure combinational steering, no state.
   assign Data_out = sel ? Data_in2 : Data_in1;

endmodule

// File: rtl/mux_arbiter_2to1.sv
// Packet-level round-robin arbiter sharing one datapath between two streams.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ARB_IDLE | no owner; pick a requester for next cycle, accept nothing
//   ARB_OWN0 | requester 0 owns the mux until last / MAX_PKT beats
//   ARB_OWN1 | requester 1 owns the mux until last / MAX_PKT beats
//
// r_rr remembers the last requester served so a tie in IDLE goes to the
// other one. The beat counter only advances on accepted beats, so a stalled
// or paused owner keeps its grant without eating into its beat budget.
module mux_arbiter_2to1
   import mux_arbiter_2to1_pkg::*;
#(
   parameter int MAX_PKT = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req0_valid,
   input  logic [DATA_BITS-1:0] req0_data,
   input  logic                 req0_last,
   output logic                 req0_ready,
   input  logic                 req1_valid,
   input  logic [DATA_BITS-1:0] req1_data,
   input  logic                 req1_last,
   output logic                 req1_ready,
   output logic                 out_valid,
   output logic [DATA_BITS-1:0] out_data,
   output logic                 out_last,
   output logic                 out_src,
   input  logic                 out_ready,
   output logic                 busy
);

   localparam int                CNT_W    = $clog2(MAX_PKT + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MAX_PKT - 1);

   arb_state_t             r_state;
   arb_state_t             w_state_nxt;
   logic                   r_rr;
   logic [CNT_W-1:0]       r_cnt;
   logic                   r_out_valid;
   logic [DATA_BITS-1:0]   r_out_data;
   logic                   r_out_last;
   logic                   r_out_src;

   logic                   w_owner;
   logic                   w_own_active;
   logic                   w_stage_free;
   logic                   w_own_valid;
   logic                   w_oth_valid;
   logic                   w_own_last;
   logic                   w_grant_ready;
   logic                   w_acc;
   logic                   w_release;
   logic [DATA_BITS-1:0]   w_mux_data;

   MUX2to1_16b u_mux (
      .sel      (w_owner),
      .Data_in1 (req0_data),
      .Data_in2 (req1_data),
      .Data_out (w_mux_data)
   );

   // Handshake decode for the current owner; readys are held low in reset.
   always_comb begin
      w_owner       = (r_state == ARB_OWN1);
      w_own_active  = (r_state != ARB_IDLE) && !rst;
      w_stage_free  = !r_out_valid || out_ready;
      w_own_valid   = w_owner ? req1_valid : req0_valid;
      w_oth_valid   = w_owner ? req0_valid : req1_valid;
      w_own_last    = w_owner ? req1_last  : req0_last;
      w_grant_ready = w_own_active && w_stage_free;
      w_acc         = w_grant_ready && w_own_valid;
      w_release     = w_acc && (w_own_last || (r_cnt == CNT_LAST));
   end

   // Next-state: round-robin pick in IDLE, handoff or idle on release.
   // The owner's own valid on the release cycle belongs to the beat just
   // taken, so only the other requester can get a zero-bubble handoff.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ARB_IDLE: begin
            if (req0_valid && req1_valid) begin
               w_state_nxt = own_state(!r_rr);
            end else if (req0_valid) begin
               w_state_nxt = ARB_OWN0;
            end else if (req1_valid) begin
               w_state_nxt = ARB_OWN1;
            end
         end
         ARB_OWN0, ARB_OWN1: begin
            if (w_release) begin
               w_state_nxt = w_oth_valid ? own_state(!w_owner) : ARB_IDLE;
            end
         end
         default: w_state_nxt = ARB_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ARB_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Round-robin pointer and per-grant beat counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rr  <= 1'b1;
         r_cnt <= '0;
      end else if (w_release) begin
         r_rr  <= w_owner;
         r_cnt <= '0;
      end else if (w_acc) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // Single-entry output stage; a load wins over a drain in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_last  <= 1'b0;
         r_out_src   <= 1'b0;
      end else if (w_acc) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_mux_data;
         r_out_last  <= w_own_last;
         r_out_src   <= w_owner;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign req0_ready = w_grant_ready && !w_owner;
   assign req1_ready = w_grant_ready &&  w_owner;
   assign out_valid  = r_out_valid;
   assign out_data   = r_out_data;
   assign out_last   = r_out_last;
   assign out_src    = r_out_src;
   assign busy       = (r_state != ARB_IDLE);

endmodule

// File: tb/tb_mux_arbiter_2to1.sv
// Self-checking bench for mux_arbiter_2to1 (MAX_PKT = 4). Requester drivers
// replay per-requester beat queues ({gap, last, data}); each scenario pushes
// the expected output order {src, last, data} into a scoreboard and pops it
// as beats leave the output stage.
module tb_mux_arbiter_2to1;

   localparam int MAX_PKT = 4;

   logic        clk;
   logic        rst;
   logic [1:0]  req_valid;
   logic [1:0]  req_last;
   logic [1:0]  req_ready;
   logic [15:0] req_data [2];
   logic        out_valid;
   logic [15:0] out_data;
   logic        out_last;
   logic        out_src;
   logic        out_ready;
   logic        busy;

   logic [17:0] q [2][$];
   logic [17:0] sb [$];
   int          n_err = 0;
   int          n_chk = 0;
   int          cyc   = 0;

   mux_arbiter_2to1 #(.MAX_PKT(MAX_PKT)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req_valid[0]),
      .req0_data  (req_data[0]),
      .req0_last  (req_last[0]),
      .req0_ready (req_ready[0]),
      .req1_valid (req_valid[1]),
      .req1_data  (req_data[1]),
      .req1_last  (req_last[1]),
      .req1_ready (req_ready[1]),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_last   (out_last),
      .out_src    (out_src),
      .out_ready  (out_ready),
      .busy       (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Requester drivers: acceptance sampled mid-cycle, next beat driven #1 after the edge.
   initial begin
      logic [1:0]  acc;
      logic [1:0]  gap_done;
      logic [17:0] hd;
      req_valid   = '0;
      req_last    = '0;
      req_data[0] = '0;
      req_data[1] = '0;
      gap_done    = '0;
      forever begin
         @(negedge clk);
         acc = req_valid & req_ready;
         @(posedge clk);
         #1;
         for (int i = 0; i < 2; i++) begin
            if (acc[i] && q[i].size() > 0) begin
               void'(q[i].pop_front());
               gap_done[i] = 1'b0;
            end
            if (q[i].size() == 0) begin
               req_valid[i] = 1'b0;
            end else begin
               hd = q[i][0];
               if (hd[17] && !gap_done[i]) begin
                  req_valid[i] = 1'b0;
                  gap_done[i]  = 1'b1;
               end else begin
                  req_valid[i] = 1'b1;
                  req_last[i]  = hd[16];
                  req_data[i]  = hd[15:0];
               end
            end
         end
      end
   end

   task automatic apply_reset;
      @(posedge clk);
      #2;
      rst       = 1'b1;
      out_ready = 1'b1;
      q[0].delete();
      q[1].delete();
      sb.delete();
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
   endtask

   task automatic test_reset;
      logic [17:0] exp;
      @(posedge clk);
      #2;
      rst       = 1'b1;
      out_ready = 1'b1;
      q[0].delete();
      q[1].delete();
      sb.delete();
      q[0].push_back({2'b01, 16'h3000});
      q[1].push_back({2'b01, 16'h4000});
      sb.push_back({1'b0, 1'b1, 16'h3000});
      sb.push_back({1'b1, 1'b1, 16'h4000});
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_chk++;
      if ({out_valid, out_last, out_src, req_ready, busy} !== 6'b0 || out_data !== 16'h0) begin
         n_err++;
         $display("FAIL reset_outputs got v=%b d=%h l=%b s=%b rdy=%b busy=%b exp all 0",
                  out_valid, out_data, out_last, out_src, req_ready, busy);
      end
      @(posedge clk);
      #2;
      rst = 1'b0;
      for (int c = 0; c < 40 && sb.size() > 0; c++) begin
         @(negedge clk);
         if (out_valid && out_ready) begin
            exp = sb.pop_front();
            n_chk++;
            if ({out_src, out_last, out_data} !== exp) begin
               n_err++;
               $display("FAIL reset_first_grant got=%h exp=%h", {out_src, out_last, out_data}, exp);
            end
         end
      end
      n_chk++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL reset_drain got=%0d left exp=0", sb.size());
      end
   endtask

   task automatic test_round_robin;
      logic [17:0] exp;
      int first;
      int seen;
      apply_reset();
      for (int b = 0; b < 3; b++) begin
         q[0].push_back({1'b0, (b == 2), 16'h1111 + 16'(b)});
         q[1].push_back({1'b0, (b == 2), 16'h2221 + 16'(b)});
      end
      for (int b = 0; b < 3; b++) sb.push_back({1'b0, (b == 2), 16'h1111 + 16'(b)});
      for (int b = 0; b < 3; b++) sb.push_back({1'b1, (b == 2), 16'h2221 + 16'(b)});
      seen  = 0;
      first = 0;
      for (int c = 0; c < 40 && sb.size() > 0; c++) begin
         @(negedge clk);
         if (out_valid && out_ready) begin
            exp = sb.pop_front();
            if (seen == 0) first = cyc;
            n_chk++;
            if ({out_src, out_last, out_data} !== exp) begin
               n_err++;
               $display("FAIL rr_beat got=%h exp=%h", {out_src, out_last, out_data}, exp);
            end
            n_chk++;
            if (cyc != first + seen) begin
               n_err++;
               $display("FAIL rr_no_bubble beat %0d got cycle=%0d exp=%0d", seen, cyc, first + seen);
            end
            seen++;
         end
      end
      n_chk++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL rr_drain got=%0d left exp=0", sb.size());
      end
   endtask

   task automatic test_forced_release;
      logic [17:0] exp;
      apply_reset();
      for (int b = 0; b < 6; b++) q[0].push_back({1'b0, (b == 5), 16'hA000 + 16'(b)});
      q[1].push_back({2'b01, 16'hB000});
      for (int b = 0; b < 4; b++) sb.push_back({1'b0, 1'b0, 16'hA000 + 16'(b)});
      sb.push_back({1'b1, 1'b1, 16'hB000});
      sb.push_back({1'b0, 1'b0, 16'hA004});
      sb.push_back({1'b0, 1'b1, 16'hA005});
      for (int c = 0; c < 60 && sb.size() > 0; c++) begin
         @(negedge clk);
         if (out_valid && out_ready) begin
            exp = sb.pop_front();
            n_chk++;
            if ({out_src, out_last, out_data} !== exp) begin
               n_err++;
               $display("FAIL forced_beat got=%h exp=%h", {out_src, out_last, out_data}, exp);
            end
         end
      end
      n_chk++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL forced_drain got=%0d left exp=0", sb.size());
      end
   endtask

   task automatic test_back_pressure;
      logic [17:0] exp;
      int seen;
      int stall;
      apply_reset();
      for (int b = 0; b < 5; b++) begin
         q[0].push_back({2'b00, 16'hC000 + 16'(b)});
         sb.push_back({2'b00, 16'hC000 + 16'(b)});
      end
      seen  = 0;
      stall = 0;
      for (int c = 0; c < 60 && sb.size() > 0; c++) begin
         @(posedge clk);
         #1;
         out_ready = !(seen >= 2 && stall < 5);
         @(negedge clk);
         if (!out_ready) begin
            stall++;
            n_chk++;
            if (out_valid !== 1'b1 || out_data !== sb[0][15:0] || req_ready[0] !== 1'b0) begin
               n_err++;
               $display("FAIL stall_hold got v=%b d=%h rdy0=%b exp v=1 d=%h rdy0=0",
                        out_valid, out_data, req_ready[0], sb[0][15:0]);
            end
         end else if (out_valid) begin
            exp = sb.pop_front();
            seen++;
            n_chk++;
            if ({out_src, out_last, out_data} !== exp) begin
               n_err++;
               $display("FAIL bp_beat got=%h exp=%h", {out_src, out_last, out_data}, exp);
            end
         end
      end
      out_ready = 1'b1;
      n_chk++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL bp_drain got=%0d left exp=0", sb.size());
      end
   endtask

   task automatic test_single_requester;
      logic [17:0] exp;
      logic prev_idle_req;
      int seen;
      int lat;
      int idle_cnt;
      apply_reset();
      q[1].push_back({2'b00, 16'hD000});
      q[1].push_back({2'b01, 16'hD001});
      q[1].push_back({2'b10, 16'hD010});
      q[1].push_back({2'b01, 16'hD011});
      sb.push_back({2'b10, 16'hD000});
      sb.push_back({2'b11, 16'hD001});
      sb.push_back({2'b10, 16'hD010});
      sb.push_back({2'b11, 16'hD011});
      prev_idle_req = 1'b0;
      seen = 0;
      lat = 0;
      idle_cnt = 0;
      for (int c = 0; c < 60 && sb.size() > 0; c++) begin
         @(negedge clk);
         if (prev_idle_req) begin
            lat++;
            n_chk++;
            if (busy !== 1'b1 || req_ready[1] !== 1'b1) begin
               n_err++;
               $display("FAIL grant_latency got busy=%b rdy1=%b exp busy=1 rdy1=1", busy, req_ready[1]);
            end
         end
         if (seen >= 1 && seen <= 2 && busy === 1'b0) idle_cnt++;
         prev_idle_req = (busy === 1'b0) && (req_valid[1] === 1'b1);
         if (out_valid && out_ready) begin
            exp = sb.pop_front();
            seen++;
            n_chk++;
            if ({out_src, out_last, out_data} !== exp) begin
               n_err++;
               $display("FAIL single_beat got=%h exp=%h", {out_src, out_last, out_data}, exp);
            end
         end
      end
      n_chk++;
      if (lat != 2) begin
         n_err++;
         $display("FAIL single_grants got=%0d exp=2", lat);
      end
      n_chk++;
      if (idle_cnt != 2) begin
         n_err++;
         $display("FAIL single_idle_gap got=%0d idle cycles exp=2", idle_cnt);
      end
      n_chk++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL single_drain got=%0d left exp=0", sb.size());
      end
   endtask

   task automatic test_mid_packet_reset;
      logic [17:0] exp;
      int seen;
      apply_reset();
      for (int b = 0; b < 5; b++) begin
         q[0].push_back({2'b00, 16'hE000 + 16'(b)});
         sb.push_back({2'b00, 16'hE000 + 16'(b)});
      end
      seen = 0;
      for (int c = 0; c < 30 && seen < 2; c++) begin
         @(negedge clk);
         if (out_valid && out_ready) begin
            exp = sb.pop_front();
            seen++;
            n_chk++;
            if ({out_src, out_last, out_data} !== exp) begin
               n_err++;
               $display("FAIL mrst_pre_beat got=%h exp=%h", {out_src, out_last, out_data}, exp);
            end
         end
      end
      @(posedge clk);
      #2;
      rst = 1'b1;
      q[0].delete();
      sb.delete();
      @(posedge clk);
      @(negedge clk);
      n_chk++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || req_ready[0] !== 1'b0) begin
         n_err++;
         $display("FAIL mrst_flush got v=%b busy=%b rdy0=%b exp 0 0 0", out_valid, busy, req_ready[0]);
      end
      @(posedge clk);
      #2;
      rst = 1'b0;
      for (int b = 0; b < 3; b++) begin
         q[0].push_back({1'b0, (b == 2), 16'hF000 + 16'(b)});
         sb.push_back({1'b0, (b == 2), 16'hF000 + 16'(b)});
      end
      for (int c = 0; c < 40 && sb.size() > 0; c++) begin
         @(negedge clk);
         if (out_valid && out_ready) begin
            exp = sb.pop_front();
            n_chk++;
            if ({out_src, out_last, out_data} !== exp) begin
               n_err++;
               $display("FAIL mrst_post_beat got=%h exp=%h", {out_src, out_last, out_data}, exp);
            end
         end
      end
      n_chk++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL mrst_drain got=%0d left exp=0", sb.size());
      end
   endtask

   initial begin
      rst       = 1'b1;
      out_ready = 1'b1;
      test_reset();
      test_round_robin();
      test_forced_release();
      test_back_pressure();
      test_single_requester();
      test_mid_packet_reset();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "watchdog expired");
   end

endmodule
